// File: rtl/mem_copy_engine_pkg.sv
`default_nettype none
//============================================================================
// Module  : fec_mem_pkg
// Brief   : Shared types and defaults for the memory copy engine
// Revision: 1.0 - initial release
//============================================================================
package fec_mem_pkg;

    // Default memory geometry for the shared data_mem bus
    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] byte_t;

    // Copy sequencer states: one read/write pair per byte, optional parity write
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        PAR  = 3'd3,
        DONE = 3'd4
    } copy_state_t;

endpackage : fec_mem_pkg
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
//============================================================================
// Module  : mem_copy_engine
// Brief   : Bus initiator that copies LEN bytes from SRC to DST one byte per
//           read/write pair, keeps a running XOR parity of the copied bytes
//           and optionally appends that parity byte at DST+LEN. Shares the
//           data_mem port with the core through a bus_req/bus_gnt handshake.
// Revision: 1.0 - initial release
//============================================================================
module mem_copy_engine
    import fec_mem_pkg::*;
#(
    parameter int ADDR_W    = int'(DEFAULT_ADDR_W),
    parameter int DATA_W    = int'(DEFAULT_DATA_W),
    parameter int LEN_W     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    // command interface
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] parity_out,
    // shared memory port arbitration
    output logic              bus_req,
    input  logic              bus_gnt,
    // data_mem port
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Sequencer state and latched command
    copy_state_t        state_q;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [DATA_W-1:0]  hold_q;
    logic [DATA_W-1:0]  parity_q;

    // Registered status outputs
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  parity_out_q;

    // Index of the byte after the one being written
    logic [LEN_W-1:0]   idx_inc;
    // Where the sequencer goes once the last data byte is written
    copy_state_t        end_state;

    assign idx_inc   = idx_q + LEN_W'(1);
    assign end_state = (PARITY_EN != 0) ? PAR : DONE;

    // Copy sequencer: latches the command, walks idx, captures read data and
    // accumulates parity; every bus state freezes while the grant is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            parity_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            parity_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q    <= src_addr;
                        dst_q    <= dst_addr;
                        len_q    <= len;
                        idx_q    <= '0;
                        parity_q <= '0;
                        busy_q   <= 1'b1;
                        if (len == '0) begin
                            // Nothing to copy: straight to the parity write
                            // (parity of an empty copy is zero) or to DONE.
                            state_q <= end_state;
                            if (end_state == DONE) begin
                                done_q       <= 1'b1;
                                parity_out_q <= '0;
                            end
                        end else begin
                            state_q <= RD;
                        end
                    end
                end

                RD: begin
                    if (bus_gnt) begin
                        hold_q   <= mem_rdata;
                        parity_q <= parity_q ^ mem_rdata;
                        state_q  <= WR;
                    end
                end

                WR: begin
                    if (bus_gnt) begin
                        idx_q <= idx_inc;
                        if (idx_inc == len_q) begin
                            state_q <= end_state;
                            if (end_state == DONE) begin
                                done_q       <= 1'b1;
                                parity_out_q <= parity_q;
                            end
                        end else begin
                            state_q <= RD;
                        end
                    end
                end

                PAR: begin
                    if (bus_gnt) begin
                        state_q      <= DONE;
                        done_q       <= 1'b1;
                        parity_out_q <= parity_q;
                    end
                end

                DONE: begin
                    // start is not sampled here; the engine only listens in IDLE
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bus drive: an access is issued only in RD/WR/PAR while granted, and
    // every bus output returns to zero when no access is issued.
    always_comb begin
        mem_address  = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_wdata    = '0;
        if (bus_gnt) begin
            unique case (state_q)
                RD: begin
                    mem_read_en = 1'b1;
                    mem_address = src_q + ADDR_W'(idx_q);
                end
                WR: begin
                    mem_write_en = 1'b1;
                    mem_address  = dst_q + ADDR_W'(idx_q);
                    mem_wdata    = hold_q;
                end
                PAR: begin
                    mem_write_en = 1'b1;
                    mem_address  = dst_q + ADDR_W'(len_q);
                    mem_wdata    = parity_q;
                end
                default: begin
                    mem_read_en = 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign parity_out = parity_out_q;
    // The request stays up for the whole job, including stalled cycles
    assign bus_req    = busy_q;

endmodule : mem_copy_engine
`default_nettype wire
